// File: rtl/adder_prefix_pipe_pkg.sv
// ---------------------------------------------------------------------------
// adder_prefix_pipe_pkg
// Shared definitions for the pipelined Kogge-Stone adder:
//   DEF_WIDTH          default operand/sum width
//   FLAG_* / flags_t   bit positions of the optional status flags
//   clog2()            ceiling log2 used to size the prefix tree
// ---------------------------------------------------------------------------
package adder_prefix_pipe_pkg;

    localparam int DEF_WIDTH = 32'sd32;

    localparam int FLAG_OVF  = 32'sd0;
    localparam int FLAG_ZERO = 32'sd1;
    localparam int FLAG_NEG  = 32'sd2;
    localparam int NUM_FLAGS = 32'sd3;

    typedef logic [NUM_FLAGS-1:0] flags_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 32'sd0;
        rem = value - 32'sd1;
        while (rem > 32'sd0) begin
            res = res + 32'sd1;
            rem = rem >>> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/adder_prefix_pipe_level.sv
// ---------------------------------------------------------------------------
// gp_cell / adder_prefix_level
// gp_cell: one Kogge-Stone black cell combining a high (g,p) pair with the
//   pair SPAN bits below it.
// adder_prefix_level: one purely combinational prefix level.
//   i_g, i_p : group generate/propagate entering the level
//   o_g, o_p : group generate/propagate leaving the level
//   Bits i >= SPAN combine with bit i-SPAN; lower bits pass unchanged.
// ---------------------------------------------------------------------------
module gp_cell (
    input  logic i_g_hi,
    input  logic i_p_hi,
    input  logic i_g_lo,
    input  logic i_p_lo,
    output logic o_g,
    output logic o_p
);
    assign o_g = i_g_hi | (i_p_hi & i_g_lo);
    assign o_p = i_p_hi & i_p_lo;
endmodule

module adder_prefix_level
    import adder_prefix_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SPAN  = 32'sd1
) (
    input  logic [WIDTH-1:0] i_g,
    input  logic [WIDTH-1:0] i_p,
    output logic [WIDTH-1:0] o_g,
    output logic [WIDTH-1:0] o_p
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= SPAN) begin : g_cell
            gp_cell u_cell (
                .i_g_hi (i_g[i]),
                .i_p_hi (i_p[i]),
                .i_g_lo (i_g[i-SPAN]),
                .i_p_lo (i_p[i-SPAN]),
                .o_g    (o_g[i]),
                .o_p    (o_p[i])
            );
        end else begin : g_pass
            assign o_g[i] = i_g[i];
            assign o_p[i] = i_p[i];
        end
    end
endmodule

// File: rtl/adder_prefix_pipe.sv
// ---------------------------------------------------------------------------
// adder_prefix_pipe
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  upstream handshake
//   a_i, b_i             operands
//   cin_i, sub_i         carry-in, subtract select (a_i - b_i, cin ignored)
//   out_valid/out_ready  downstream handshake
//   sum_o, cout_o        result and carry-out
//   ovf_o, zero_o, neg_o status flags, present only when ADDER_PIPE_FLAGS_EN
//                        is defined
// A register stage follows every REG_EVERY prefix levels and the last level;
// the final sum XOR is formed after the last register.
// ---------------------------------------------------------------------------
module adder_prefix_pipe
    import adder_prefix_pipe_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int REG_EVERY = 32'sd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
`ifdef ADDER_PIPE_FLAGS_EN
    ,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             neg_o
`endif
);
    localparam int L = clog2(WIDTH);
    localparam int N = (L + REG_EVERY - 32'sd1) / REG_EVERY;

    logic [WIDTH-1:0] w_b_eff, w_g0, w_p0;
    logic             w_cin_eff;

    // Stage inputs (from operand conditioning or previous register)
    logic [WIDTH-1:0] w_sg [N];
    logic [WIDTH-1:0] w_sp [N];
    logic [WIDTH-1:0] w_spo [N];
    logic             w_scin [N];
    logic [N-1:0]     w_up_v;
    // Prefix level outputs and per-stage next data
    logic [WIDTH-1:0] w_lg [L];
    logic [WIDTH-1:0] w_lp [L];
    logic [WIDTH-1:0] w_ng [N];
    logic [WIDTH-1:0] w_np [N];
    // Stage registers
    logic [N-1:0]     r_v;
    logic [WIDTH-1:0] r_g [N];
    logic [WIDTH-1:0] r_p [N];
    logic [WIDTH-1:0] r_po [N];
    logic             r_cin [N];
    logic [N-1:0]     w_adv, w_rdy;
`ifdef ADDER_PIPE_FLAGS_EN
    logic             w_sam [N];
    logic             w_sbm [N];
    logic             r_am [N];
    logic             r_bm [N];
    flags_t           w_flags;
`endif

    // Condition operands; carry-in is folded into the bit-0 generate
    always_comb begin
        w_b_eff   = sub_i ? ~b_i : b_i;
        w_cin_eff = sub_i ? 1'b1 : cin_i;
        w_p0      = a_i ^ w_b_eff;
        w_g0      = a_i & w_b_eff;
        w_g0[0]   = w_g0[0] | (w_p0[0] & w_cin_eff);
    end

    for (genvar k = 0; k < N; k++) begin : g_stage_in
        if (k == 0) begin : g_first
            assign w_sg[k]   = w_g0;
            assign w_sp[k]   = w_p0;
            assign w_spo[k]  = w_p0;
            assign w_scin[k] = w_cin_eff;
            assign w_up_v[k] = in_valid;
`ifdef ADDER_PIPE_FLAGS_EN
            assign w_sam[k]  = a_i[WIDTH-1];
            assign w_sbm[k]  = w_b_eff[WIDTH-1];
`endif
        end else begin : g_next
            assign w_sg[k]   = r_g[k-1];
            assign w_sp[k]   = r_p[k-1];
            assign w_spo[k]  = r_po[k-1];
            assign w_scin[k] = r_cin[k-1];
            assign w_up_v[k] = r_v[k-1];
`ifdef ADDER_PIPE_FLAGS_EN
            assign w_sam[k]  = r_am[k-1];
            assign w_sbm[k]  = r_bm[k-1];
`endif
        end
    end

    // Level j feeds from the stage register when it opens a stage,
    // otherwise from the level just below it.
    for (genvar j = 0; j < L; j++) begin : g_level
        localparam int K    = j / REG_EVERY;
        localparam int SPAN = 32'sd1 <<< j;
        logic [WIDTH-1:0] w_gi, w_pi;
        if ((j % REG_EVERY) == 0) begin : g_from_stage
            assign w_gi = w_sg[K];
            assign w_pi = w_sp[K];
        end else begin : g_from_level
            assign w_gi = w_lg[j-1];
            assign w_pi = w_lp[j-1];
        end
        adder_prefix_level #(.WIDTH(WIDTH), .SPAN(SPAN)) u_level (
            .i_g (w_gi),
            .i_p (w_pi),
            .o_g (w_lg[j]),
            .o_p (w_lp[j])
        );
    end

    for (genvar k = 0; k < N; k++) begin : g_stage_out
        localparam int END_LVL  = (k + 1) * REG_EVERY;
        localparam int LAST_LVL = ((END_LVL < L) ? END_LVL : L) - 32'sd1;
        assign w_ng[k] = w_lg[LAST_LVL];
        assign w_np[k] = w_lp[LAST_LVL];
    end

    // Advance/ready chain, walked from the output stage backwards
    always_comb begin
        logic dn_rdy;
        w_adv  = {N{1'b0}};
        w_rdy  = {N{1'b0}};
        dn_rdy = out_ready;
        for (int k = N - 1; k >= 0; k--) begin
            w_adv[k] = r_v[k] & dn_rdy;
            w_rdy[k] = ~r_v[k] | w_adv[k];
            dn_rdy   = w_rdy[k];
        end
    end

    // Stage valid bits: a ready stage takes whatever valid is upstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= {N{1'b0}};
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w_rdy[k]) begin
                    r_v[k] <= w_up_v[k];
                end else begin
                    r_v[k] <= r_v[k];
                end
            end
        end
    end

    // Stage data: loads only on an actual transfer into the stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                r_g[k]   <= {WIDTH{1'b0}};
                r_p[k]   <= {WIDTH{1'b0}};
                r_po[k]  <= {WIDTH{1'b0}};
                r_cin[k] <= 1'b0;
`ifdef ADDER_PIPE_FLAGS_EN
                r_am[k]  <= 1'b0;
                r_bm[k]  <= 1'b0;
`endif
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w_rdy[k] & w_up_v[k]) begin
                    r_g[k]   <= w_ng[k];
                    r_p[k]   <= w_np[k];
                    r_po[k]  <= w_spo[k];
                    r_cin[k] <= w_scin[k];
`ifdef ADDER_PIPE_FLAGS_EN
                    r_am[k]  <= w_sam[k];
                    r_bm[k]  <= w_sbm[k];
`endif
                end
            end
        end
    end

    // Carry into bit i is the prefix generate of bit i-1 (bit 0: carry-in)
    assign in_ready  = w_rdy[0];
    assign out_valid = r_v[N-1];
    assign sum_o     = r_po[N-1] ^ {r_g[N-1][WIDTH-2:0], r_cin[N-1]};
    assign cout_o    = r_g[N-1][WIDTH-1];

`ifdef ADDER_PIPE_FLAGS_EN
    // Status flags from the final register; zero is qualified by valid so
    // the idle/reset state reads as all-flags-clear
    always_comb begin
        w_flags            = {NUM_FLAGS{1'b0}};
        w_flags[FLAG_OVF]  = (r_am[N-1] ~^ r_bm[N-1]) & (sum_o[WIDTH-1] ^ r_am[N-1]);
        w_flags[FLAG_ZERO] = r_v[N-1] & (sum_o == {WIDTH{1'b0}});
        w_flags[FLAG_NEG]  = sum_o[WIDTH-1];
    end

    assign ovf_o  = w_flags[FLAG_OVF];
    assign zero_o = w_flags[FLAG_ZERO];
    assign neg_o  = w_flags[FLAG_NEG];
`endif

endmodule

// File: tb/tb_adder_prefix_pipe.sv
// ---------------------------------------------------------------------------
// tb_adder_prefix_pipe
// Scoreboard bench for adder_prefix_pipe: expected results are queued when
// an operand is accepted and compared when a result is taken.  Optional
// flag checks follow ADDER_PIPE_FLAGS_EN.
// ---------------------------------------------------------------------------
module tb_adder_prefix_pipe #(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 1
);
    localparam int L = $clog2(WIDTH);
    localparam int N = (L + REG_EVERY - 1) / REG_EVERY;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic             neg;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             sub_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
`ifdef ADDER_PIPE_FLAGS_EN
    logic             ovf_o, zero_o, neg_o;
`endif

    int n_total = 0;
    int n_bad   = 0;
    exp_t sb[$];

    adder_prefix_pipe #(.WIDTH(WIDTH), .REG_EVERY(REG_EVERY)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .cin_i     (cin_i),
        .sub_i     (sub_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_o     (sum_o),
        .cout_o    (cout_o)
`ifdef ADDER_PIPE_FLAGS_EN
        ,
        .ovf_o     (ovf_o),
        .zero_o    (zero_o),
        .neg_o     (neg_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached (total=%0d bad=%0d)", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic c, input logic s);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   u;
        logic [WIDTH+1:0] sx;
        logic             ci;
        exp_t             e;
        bb = s ? ~b : b;
        ci = s ? 1'b1 : c;
        u  = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
        sx = {a[WIDTH-1], a[WIDTH-1], a} + {bb[WIDTH-1], bb[WIDTH-1], bb}
           + {{(WIDTH+1){1'b0}}, ci};
        e.sum  = u[WIDTH-1:0];
        e.cout = u[WIDTH];
        e.ovf  = (sx[WIDTH] != sx[WIDTH-1]);
        e.zero = (u[WIDTH-1:0] == {WIDTH{1'b0}});
        e.neg  = u[WIDTH-1];
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [WIDTH-1:0] r;
        int sel;
        r   = {WIDTH{1'b0}};
        sel = $urandom_range(0, 7);
        if (sel == 0)      r = {WIDTH{1'b1}};
        else if (sel == 1) r[WIDTH-1] = 1'b1;
        else if (sel == 2) r = {WIDTH{1'b0}};
        else for (int i = 0; i < WIDTH; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic rand_ops();
        a_i   = rnd_word();
        b_i   = rnd_word();
        cin_i = 1'($urandom_range(0, 1));
        sub_i = 1'($urandom_range(0, 1));
    endtask

    // Monitor: queue on accept, compare on output transfer, check hold
    logic             hold_chk = 1'b0;
    logic [WIDTH-1:0] h_sum;
    logic             h_cout;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (in_valid && in_ready) sb.push_back(model(a_i, b_i, cin_i, sub_i));
            if (hold_chk) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_sum", sum_o, h_sum);
                chk("hold_cout", cout_o, h_cout);
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sum", sum_o, e.sum);
                    chk("cout", cout_o, e.cout);
`ifdef ADDER_PIPE_FLAGS_EN
                    chk("ovf", ovf_o, e.ovf);
                    chk("zero", zero_o, e.zero);
                    chk("neg", neg_o, e.neg);
`endif
                end
            end
            hold_chk = out_valid && !out_ready;
            h_sum    = sum_o;
            h_cout   = cout_o;
        end else begin
            hold_chk = 1'b0;
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_sum"}, sum_o, 0);
        chk({tag, "_cout"}, cout_o, 0);
`ifdef ADDER_PIPE_FLAGS_EN
        chk({tag, "_flags"}, {ovf_o, zero_o, neg_o}, 0);
`endif
    endtask

    // One operation on an empty pipe; measures accept-to-out_valid cycles
    task automatic single_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic c, input logic s);
        int  lat;
        bit  seen;
        out_ready = 1'b1;
        a_i = a; b_i = b; cin_i = c; sub_i = s;
        in_valid = 1'b1;
        seen = 1'b0;
        for (int g = 0; g < 20 && !seen; g++) begin
            @(negedge clk);
            if (in_ready) seen = 1'b1;
        end
        chk("accept", seen, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rand_ops();
        lat  = 0;
        seen = 1'b0;
        for (int cy = 1; cy <= N + 4 && !seen; cy++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                lat  = cy;
            end
        end
        chk("latency", lat, N);
        @(posedge clk); #1;
    endtask

    task automatic run_stream(input int cnt, input bit bp);
        int sent = 0;
        int cyc  = 0;
        int gaps = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        rand_ops();
        while (sent < cnt && cyc < cnt * 20) begin
            @(negedge clk);
            if (in_ready) sent++;
            if (!bp && cyc >= N && !out_valid) gaps++;
            cyc++;
            @(posedge clk); #1;
            rand_ops();
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent >= cnt) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_sent", sent, cnt);
        if (!bp) begin
            chk("stream_rate", cyc, cnt);
            chk("stream_gaps", gaps, 0);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int g = 0; g < 8 * N + 20 && sb.size() != 0; g++) @(negedge clk);
        @(posedge clk); #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int acc;
        logic [WIDTH-1:0] v;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        rand_ops();
        repeat (2) @(negedge clk);
        chk_idle("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // all-ones + 1 wraps to zero with carry-out
        v = {WIDTH{1'b1}};
        single_op(v, 1, 1'b0, 1'b0);
        drain();
        // 5 - 7 and min_signed - 1
        single_op(5, 7, 1'b0, 1'b1);
        drain();
        v = {WIDTH{1'b0}};
        v[WIDTH-1] = 1'b1;
        single_op(v, 1, 1'b0, 1'b1);
        drain();
        single_op(v, v, 1'b1, 1'b0);
        drain();

        // back-to-back throughput, then random backpressure
        run_stream(100, 1'b0);
        drain();
        run_stream(40, 1'b1);
        drain();

        // stall with downstream blocked: exactly N accepted
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        for (int cy = 0; cy < 10; cy++) begin
            @(negedge clk);
            if (in_ready) acc++;
            if (cy == 9) chk("stall_in_ready", in_ready, 0);
            @(posedge clk); #1;
            rand_ops();
        end
        chk("stall_accepted", acc, N);
        drain();

        // reset in the middle of three in-flight operations
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            rand_ops();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        @(negedge clk);
        chk_idle("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        acc = 0;
        for (int cy = 0; cy < N + 2; cy++) begin
            @(negedge clk);
            if (out_valid || !in_ready) acc++;
        end
        chk("post_rst_quiet", acc, 0);
        @(posedge clk); #1;
        single_op(12345, 678, 1'b1, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/adder_prefix_pipe.md
ADDER_PREFIX_PIPE -- requirements
Module: adder_prefix_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width in bits (power of two, 8..128).
REQ-002 SHALL have parameter REG_EVERY, default 1, number of prefix levels between pipeline registers (1..clog2(WIDTH)).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1: upstream valid/ready handshake.
REQ-006 SHALL have ports a_i, b_i input WIDTH: operands.
REQ-007 SHALL have ports cin_i input 1 (carry-in), sub_i input 1 (1 = subtract a_i - b_i).
REQ-008 SHALL have ports out_valid output 1, out_ready input 1: downstream handshake.
REQ-009 SHALL have ports sum_o output WIDTH, cout_o output 1: result and carry-out.
REQ-010 SHALL have ports ovf_o, zero_o, neg_o output 1 each: signed overflow, zero, sign flags (present only per REQ-027).

Function
REQ-011 SHALL compute {cout_o,sum_o} = a_i + (sub_i ? ~b_i : b_i) + (sub_i ? 1 : cin_i), modulo 2^(WIDTH+1).
REQ-012 SHALL form bitwise g = a&b', p = a^b', fold effective carry-in into bit 0 generate, then run L = clog2(WIDTH) Kogge-Stone levels, level j combining bit i with bit i-2^j for i >= 2^j, passing bits i < 2^j unchanged.
REQ-013 SHALL place a pipeline register after every REG_EVERY levels and after the last level; N = ceil(L/REG_EVERY) register stages; sum = p ^ {carry prefix, cin} computed after the final register.
REQ-014 SHALL carry p, original operand MSBs and effective carry-in alongside g/p through every stage.
REQ-015 SHALL give latency exactly N cycles from accepted input (in_valid&in_ready) to out_valid with no stall (WIDTH=32: N=5 at REG_EVERY=1, N=3 at REG_EVERY=2).
REQ-016 SHALL keep one valid bit per stage; stage k loads when stage k empty or stage k advances; final stage advances when out_ready.
REQ-017 SHALL collapse bubbles: an empty stage accepts data even while downstream stalls.
REQ-018 SHALL drive in_ready = !v[0] | advance[0], combinationally; in_ready not dependent on in_valid.
REQ-019 SHALL hold sum_o, cout_o, flags and out_valid stable while out_valid & !out_ready.
REQ-020 SHALL accept a new operand and emit a result in the same cycle when full and out_ready=1 (throughput 1/cycle).
REQ-021 SHALL never drop or duplicate a transaction; results emerge in issue order.
REQ-022 SHALL ignore a_i/b_i/cin_i/sub_i when in_valid=0 or in_ready=0.

Reset
REQ-023 SHALL clear all stage valid bits asynchronously on rst_n=0; out_valid=0, in_ready=1 during and after reset.
REQ-024 SHALL reset data registers to 0 (sum_o=0, cout_o=0, flags=0).
REQ-025 SHALL discard in-flight transactions on reset mid-operation; no result emitted after release.
REQ-026 SHALL release reset synchronously from rst_n deassertion on the next clk edge; first accept possible that edge.

Configuration
REQ-027 SHALL, with ADDER_PIPE_FLAGS_EN defined, produce ovf_o = (a_msb ~^ b'_msb) & (sum_msb ^ a_msb), zero_o = (sum_o==0), neg_o = sum_msb, registered with sum_o.
REQ-028 SHALL, without ADDER_PIPE_FLAGS_EN, omit ovf_o/zero_o/neg_o ports and their MSB tracking registers.

Structure
REQ-029 SHALL take default WIDTH and flag-index constants from the shared main definitions package; clog2 helper lives there.
REQ-030 SHALL instantiate one sub-module adder_prefix_level (parameters WIDTH, SPAN) per prefix level, built from existing gp_cell instances.
REQ-031 SHALL contain pipeline control (valid bits, advance chain) only in the top module; adder_prefix_level is purely combinational.

Verification
REQ-032 WIDTH=32, REG_EVERY=1: a=0xFFFFFFFF, b=1, cin=0, sub=0 -> after 5 cycles sum=0, cout=1, zero=1.
REQ-033 sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0, neg=1, ovf=0; a=0x80000000, b=1 -> sum=0x7FFFFFFF, ovf=1.
REQ-034 Back-to-back 100 random ops, out_ready=1 -> out_valid every cycle after 5-cycle fill, results match model in order.
REQ-035 Hold out_ready=0 for 10 cycles with in_valid=1 -> exactly 5 accepted, then in_ready=0; outputs stable; release -> all 5 emerge in order.
REQ-036 Issue 3 ops, assert rst_n=0 for one cycle at cycle 2 -> out_valid stays 0, in_ready=1; next op returns correct result after 5 cycles.
REQ-037 Repeat REQ-032..035 at WIDTH=64, REG_EVERY=2 (N=3) with and without ADDER_PIPE_FLAGS_EN.
